// File: rtl/st_tri_splitter_pkg.sv
// Shared channel indices and helpers for the three-way stream splitter.
package st_split_pkg;

  localparam int NUM_CH = 3;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH_A = 2'd0;
  localparam ch_idx_t CH_B = 2'd1;
  localparam ch_idx_t CH_C = 2'd2;

  // Round-robin successor; an illegal index falls back to channel A
  function automatic ch_idx_t next_ch(input ch_idx_t c);
    ch_idx_t n;
    case (c)
      CH_A:    n = CH_B;
      CH_B:    n = CH_C;
      CH_C:    n = CH_A;
      default: n = CH_A;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/st_tri_splitter_if.sv
// Avalon-ST byte stream bundle; the master drives data/valid/sop, the slave drives ready.
interface st_tri_splitter_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              startofpacket;
  logic              ready;

  modport master (output data, output valid, output startofpacket, input ready);
  modport slave  (input data, input valid, input startofpacket, output ready);
endinterface

// File: rtl/st_tri_splitter_fifo.sv
// Per-channel synchronous FIFO with wrapping rd/wr pointers and an occupancy count.
module st_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_W + 1;

  logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_BITS-1:0] count_r;
  logic                full_s;
  logic                empty_s;
  logic                do_push_s;
  logic                do_pop_s;

  assign full_s    = (count_r == CNT_BITS'(FIFO_DEPTH));
  assign empty_s   = (count_r == {CNT_BITS{1'b0}});
  assign do_push_s = push & ~full_s;
  assign do_pop_s  = pop & ~empty_s;

  assign full  = full_s;
  assign empty = empty_s;
  assign head  = mem_r[rd_ptr_r];

  // Storage, pointers and count; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_BITS{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_BITS'(1);
        2'b01:   count_r <= count_r - CNT_BITS'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/st_tri_splitter.sv
// Deals one byte stream round-robin into three buffered channels (A, B, C);
// SOP always restarts the deal at A.
module st_tri_splitter
  import st_split_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 csi_clk,
  input  logic                 rsi_reset_n,
  st_tri_splitter_if.slave     asi_in,
  st_tri_splitter_if.master    aso_out0,
  st_tri_splitter_if.master    aso_out1,
  st_tri_splitter_if.master    aso_out2,
  output logic [CNT_W-1:0]     coe_triplets,
  output logic                 coe_resync
);

  ch_idx_t             ptr_r;
  ch_idx_t             tgt_s;
  logic [CNT_W-1:0]    triplets_r;
  logic                resync_r;
  logic [NUM_CH-1:0]   full_s;
  logic [NUM_CH-1:0]   empty_s;
  logic [NUM_CH-1:0]   push_s;
  logic [NUM_CH-1:0]   pop_s;
  logic [NUM_CH-1:0]   out_ready_s;
  logic [DATA_W-1:0]   head_s [NUM_CH];
  logic                tgt_full_s;
  logic                in_ready_s;
  logic                hs_s;

  assign out_ready_s = {aso_out2.ready, aso_out1.ready, aso_out0.ready};
  assign pop_s       = ~empty_s & out_ready_s;

  // Target selection and input ready; ready looks only at registered FIFO counts
  always_comb begin
    tgt_s      = ptr_r;
    tgt_full_s = 1'b1;
    push_s     = {NUM_CH{1'b0}};
    if (asi_in.startofpacket) begin
      tgt_s = CH_A;
    end else begin
      tgt_s = ptr_r;
    end
    case (tgt_s)
      CH_A:    tgt_full_s = full_s[0];
      CH_B:    tgt_full_s = full_s[1];
      CH_C:    tgt_full_s = full_s[2];
      default: tgt_full_s = 1'b1;
    endcase
    in_ready_s = rsi_reset_n & ~tgt_full_s;
    hs_s       = asi_in.valid & in_ready_s;
    case (tgt_s)
      CH_A:    push_s = {2'b00, hs_s};
      CH_B:    push_s = {1'b0, hs_s, 1'b0};
      CH_C:    push_s = {hs_s, 2'b00};
      default: push_s = {NUM_CH{1'b0}};
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    st_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (csi_clk),
      .rst_n     (rsi_reset_n),
      .push      (push_s[i]),
      .push_data (asi_in.data),
      .pop       (pop_s[i]),
      .full      (full_s[i]),
      .empty     (empty_s[i]),
      .head      (head_s[i])
    );
  end

  // Deal pointer, completed-triplet counter and one-cycle resync flag
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      ptr_r      <= CH_A;
      triplets_r <= {CNT_W{1'b0}};
      resync_r   <= 1'b0;
    end else begin
      if (hs_s) begin
        ptr_r    <= next_ch(tgt_s);
        resync_r <= asi_in.startofpacket & (ptr_r != CH_A);
        if (tgt_s == CH_C) begin
          triplets_r <= triplets_r + CNT_W'(1);
        end
      end else begin
        resync_r <= 1'b0;
      end
    end
  end

  assign asi_in.ready           = in_ready_s;
  assign aso_out0.valid         = ~empty_s[0];
  assign aso_out1.valid         = ~empty_s[1];
  assign aso_out2.valid         = ~empty_s[2];
  assign aso_out0.data          = head_s[0];
  assign aso_out1.data          = head_s[1];
  assign aso_out2.data          = head_s[2];
  assign aso_out0.startofpacket = 1'b0;
  assign aso_out1.startofpacket = 1'b0;
  assign aso_out2.startofpacket = 1'b0;
  assign coe_triplets           = triplets_r;
  assign coe_resync             = resync_r;

endmodule

// File: tb/tb_st_tri_splitter.sv
// Randomized and directed checks of st_tri_splitter against a queue-based reference.
module tb_st_tri_splitter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic [2:0]  out_ready = 3'b000;
  logic [15:0] trip;
  logic        resync;
  logic [2:0]  out_valid;
  logic [7:0]  out_data [3];

  logic        w_valid = 1'b0;
  logic [2:0]  w_trip;
  logic        w_resync;

  int n_checks = 0;
  int n_errors = 0;
  int res_cnt  = 0;

  // reference model state
  logic [7:0]  mq  [3][$];
  logic [7:0]  obs [3][$];
  int          mptr = 0;
  logic [15:0] mtrip = 16'd0;
  bit          mres = 1'b0;

  always #5 clk = ~clk;

  st_tri_splitter_if #(.DATA_W(8)) in_if ();
  st_tri_splitter_if #(.DATA_W(8)) o0_if ();
  st_tri_splitter_if #(.DATA_W(8)) o1_if ();
  st_tri_splitter_if #(.DATA_W(8)) o2_if ();

  assign in_if.data          = in_data;
  assign in_if.valid         = in_valid;
  assign in_if.startofpacket = in_sop;
  assign o0_if.ready = out_ready[0];
  assign o1_if.ready = out_ready[1];
  assign o2_if.ready = out_ready[2];
  assign out_valid   = {o2_if.valid, o1_if.valid, o0_if.valid};
  assign out_data[0] = o0_if.data;
  assign out_data[1] = o1_if.data;
  assign out_data[2] = o2_if.data;

  st_tri_splitter #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .csi_clk      (clk),
    .rsi_reset_n  (rst_n),
    .asi_in       (in_if),
    .aso_out0     (o0_if),
    .aso_out1     (o1_if),
    .aso_out2     (o2_if),
    .coe_triplets (trip),
    .coe_resync   (resync)
  );

  // Narrow-counter instance used only to exercise the wrap of coe_triplets
  st_tri_splitter_if #(.DATA_W(8)) w_in_if ();
  st_tri_splitter_if #(.DATA_W(8)) w_o0_if ();
  st_tri_splitter_if #(.DATA_W(8)) w_o1_if ();
  st_tri_splitter_if #(.DATA_W(8)) w_o2_if ();

  assign w_in_if.data          = 8'hA5;
  assign w_in_if.valid         = w_valid;
  assign w_in_if.startofpacket = 1'b0;
  assign w_o0_if.ready = 1'b1;
  assign w_o1_if.ready = 1'b1;
  assign w_o2_if.ready = 1'b1;

  st_tri_splitter #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut_w (
    .csi_clk      (clk),
    .rsi_reset_n  (rst_n),
    .asi_in       (w_in_if),
    .aso_out0     (w_o0_if),
    .aso_out1     (w_o1_if),
    .aso_out2     (w_o2_if),
    .coe_triplets (w_trip),
    .coe_resync   (w_resync)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare outputs with the model, log pops, then advance the model to the next edge
  always @(negedge clk) begin : cmp
    int  t;
    bit  hs;
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) mq[c].delete();
      mptr  = 0;
      mtrip = 16'd0;
      mres  = 1'b0;
    end
    t = in_sop ? 0 : mptr;
    check("in_ready", {31'd0, in_if.ready}, {31'd0, (rst_n && mq[t].size() < DEPTH)});
    check("triplets", {16'd0, trip}, {16'd0, mtrip});
    check("resync", {31'd0, resync}, {31'd0, mres});
    for (int c = 0; c < 3; c++) begin
      check($sformatf("valid%0d", c), {31'd0, out_valid[c]}, {31'd0, (mq[c].size() != 0)});
      if (mq[c].size() != 0) begin
        check($sformatf("data%0d", c), {24'd0, out_data[c]}, {24'd0, mq[c][0]});
      end
      if (out_valid[c] && out_ready[c]) obs[c].push_back(out_data[c]);
    end
    if (resync) res_cnt++;
    if (rst_n) begin
      hs = in_valid && (mq[t].size() < DEPTH);
      for (int c = 0; c < 3; c++) begin
        if (mq[c].size() != 0 && out_ready[c]) void'(mq[c].pop_front());
      end
      if (hs) begin
        mq[t].push_back(in_data);
        if (t == 2) mtrip = mtrip + 16'd1;
        mres = in_sop && (mptr != 0);
        mptr = (t + 1) % 3;
      end else begin
        mres = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] d, input logic s, input int maxc, output bit ok);
    in_data = d; in_sop = s; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      ok = in_if.ready;
      tick();
    end
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic s, input string nm);
    bit ok;
    offer(d, s, 20, ok);
    check(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_seq(input string nm, input int ch, input int n, input int exp [5]);
    check({nm, "_len"}, obs[ch].size(), n);
    for (int i = 0; i < n; i++) begin
      check(nm, (i < obs[ch].size()) ? {24'd0, obs[ch][i]} : 32'hFFFF_FFFF, exp[i]);
    end
  endtask

  task automatic clear_obs();
    for (int c = 0; c < 3; c++) obs[c].delete();
  endtask

  initial begin
    bit ok;
    #2;
    check("rst_ready", {31'd0, in_if.ready}, 32'd0);
    check("rst_valid", {29'd0, out_valid}, 32'd0);
    check("rst_trip", {16'd0, trip}, 32'd0);
    check("rst_resync", {31'd0, resync}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    // 1: plain round-robin deal
    out_ready = 3'b111;
    clear_obs();
    for (int b = 1; b <= 6; b++) send(8'(b), 1'b0, "t1_accept");
    repeat (3) tick();
    chk_seq("t1_out0", 0, 2, '{1, 4, 0, 0, 0});
    chk_seq("t1_out1", 1, 2, '{2, 5, 0, 0, 0});
    chk_seq("t1_out2", 2, 2, '{3, 6, 0, 0, 0});
    check("t1_trip", {16'd0, trip}, 32'd2);

    // 2: stalled channel B back-pressures only when it is next
    out_ready = 3'b101;
    clear_obs();
    for (int b = 1; b <= 13; b++) send(8'(b), 1'b0, "t2_accept");
    offer(8'd14, 1'b0, 3, ok);
    check("t2_14_blocked", {31'd0, ok}, 32'd0);
    in_data = 8'd14; in_valid = 1'b1; out_ready = 3'b111;
    @(negedge clk);
    check("t2_ready_pop_cycle", {31'd0, in_if.ready}, 32'd0);
    tick();
    @(negedge clk);
    check("t2_ready_after", {31'd0, in_if.ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    send(8'd15, 1'b0, "t2_accept15");
    repeat (8) tick();
    chk_seq("t2_out1", 1, 5, '{2, 5, 8, 11, 14});
    check("t2_trip", {16'd0, trip}, 32'd7);

    // 3: SOP mid-triplet resynchronises to channel A
    clear_obs();
    res_cnt = 0;
    send(8'd10, 1'b0, "t3_a10");
    send(8'd20, 1'b0, "t3_a20");
    send(8'd30, 1'b1, "t3_a30");
    send(8'd40, 1'b0, "t3_a40");
    repeat (4) tick();
    chk_seq("t3_out0", 0, 2, '{10, 30, 0, 0, 0});
    chk_seq("t3_out1", 1, 2, '{20, 40, 0, 0, 0});
    check("t3_resync_cycles", res_cnt, 32'd1);
    check("t3_trip", {16'd0, trip}, 32'd7);

    // 4: pop from a full FIFO does not raise ready in the same cycle
    out_ready = 3'b110;
    for (int b = 0; b < 4; b++) send(8'hA1 + 8'(b), 1'b1, "t4_fill");
    in_data = 8'hA5; in_sop = 1'b1; in_valid = 1'b1; out_ready = 3'b111;
    @(negedge clk);
    check("t4_ready_pop_cycle", {31'd0, in_if.ready}, 32'd0);
    tick();
    @(negedge clk);
    check("t4_ready_after", {31'd0, in_if.ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_sop = 1'b0;
    repeat (8) tick();

    // 5: reset mid-operation discards queued data
    out_ready = 3'b000;
    send(8'd1, 1'b0, "t5_q1");
    send(8'd2, 1'b0, "t5_q2");
    send(8'd3, 1'b0, "t5_q3");
    check("t5_pre_valid", {29'd0, out_valid}, 32'd7);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_valid_drop", {29'd0, out_valid}, 32'd0);
    check("t5_trip_clr", {16'd0, trip}, 32'd0);
    check("t5_ready_rst", {31'd0, in_if.ready}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 3'b111;
    clear_obs();
    send(8'h55, 1'b0, "t5_a55");
    repeat (3) tick();
    chk_seq("t5_out0", 0, 1, '{8'h55, 0, 0, 0, 0});
    check("t5_out1_len", obs[1].size(), 32'd0);

    // 6: counter wrap on the narrow instance
    w_valid = 1'b1;
    repeat (21) tick();
    check("t6_trip7", {29'd0, w_trip}, 32'd7);
    repeat (3) tick();
    check("t6_trip_wrap", {29'd0, w_trip}, 32'd0);
    w_valid = 1'b0;

    // randomized traffic, checked each cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sop    = ($urandom_range(0, 9) == 0);
      in_data   = 8'($urandom);
      out_ready = 3'($urandom);
      tick();
    end
    in_valid = 1'b0; in_sop = 1'b0; out_ready = 3'b111;
    repeat (10) tick();
    check("final_empty", {29'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
